// File: rtl/mult_fix_seq_32_8.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per cycle, LSB first,
// with the product saturated to A_WIDTH bits and a saturation flag on tuser.
module mult_fix_seq_32_8 #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned B_WIDTH = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               s_axis_a_tvalid,
    input  logic [A_WIDTH-1:0] s_axis_a_tdata,
    input  logic               s_axis_b_tvalid,
    input  logic [B_WIDTH-1:0] s_axis_b_tdata,
    output logic               s_axis_tready,
    output logic               m_axis_result_tvalid,
    output logic [A_WIDTH-1:0] m_axis_result_tdata,
    output logic               m_axis_result_tuser
);

    localparam int unsigned ACC_W = A_WIDTH + B_WIDTH;
    localparam int unsigned CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_next;

    logic [A_WIDTH-1:0] r_a;
    logic [B_WIDTH-1:0] r_b;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tready;
    logic               r_tvalid;
    logic [A_WIDTH-1:0] r_tdata;
    logic               r_tuser;

    // Next-state decode; an accept needs both channels valid while idle
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_axis_a_tvalid && s_axis_b_tvalid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(B_WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One partial product per iteration; anything above A_WIDTH means saturation
    always_comb begin
        w_acc_next = r_acc + (r_b[r_cnt] ? (ACC_W'(r_a) << r_cnt) : ACC_W'(0));
        w_sat      = |w_acc_next[ACC_W-1:A_WIDTH];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_tready <= 1'b1;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= 1'b0;
        end else begin
            r_tready <= (w_state_next == S_IDLE);
            r_tvalid <= w_last;
            if (w_accept) begin
                r_a   <= s_axis_a_tdata;
                r_b   <= s_axis_b_tdata;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Result registers only change on DONE entry and hold otherwise
            if (w_last) begin
                r_tdata <= w_sat ? {A_WIDTH{1'b1}} : w_acc_next[A_WIDTH-1:0];
                r_tuser <= w_sat;
            end
        end
    end

    assign s_axis_tready        = r_tready;
    assign m_axis_result_tvalid = r_tvalid;
    assign m_axis_result_tdata  = r_tdata;
    assign m_axis_result_tuser  = r_tuser;

endmodule

// File: tb/tb_mult_fix_seq_32_8.sv
// Self-checking bench for mult_fix_seq_32_8: directed corner cases plus randomized
// operands compared against a plain-arithmetic saturating product model.
module tb_mult_fix_seq_32_8;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_axis_a_tvalid;
    logic [AW-1:0] s_axis_a_tdata;
    logic          s_axis_b_tvalid;
    logic [BW-1:0] s_axis_b_tdata;
    logic          s_axis_tready;
    logic          m_axis_result_tvalid;
    logic [AW-1:0] m_axis_result_tdata;
    logic          m_axis_result_tuser;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    mult_fix_seq_32_8 #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_a_tvalid      (s_axis_a_tvalid),
        .s_axis_a_tdata       (s_axis_a_tdata),
        .s_axis_b_tvalid      (s_axis_b_tvalid),
        .s_axis_b_tdata       (s_axis_b_tdata),
        .s_axis_tready        (s_axis_tready),
        .m_axis_result_tvalid (m_axis_result_tvalid),
        .m_axis_result_tdata  (m_axis_result_tdata),
        .m_axis_result_tuser  (m_axis_result_tuser)
    );

    // Reference: full product, clamped to AW bits; returns {sat, data}
    function automatic logic [AW:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (p > 64'h0000_0000_FFFF_FFFF) return {1'b1, {AW{1'b1}}};
        return {1'b0, p[AW-1:0]};
    endfunction

    // Issue one operation and observe it; lat is -1 if no strobe appears
    task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                          output int lat, output logic [AW-1:0] d, output logic u,
                          output logic after_valid, output logic after_ready,
                          output logic [AW-1:0] after_data, output logic busy_ready);
        @(negedge aclk);
        s_axis_a_tdata  = a;
        s_axis_b_tdata  = b;
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        lat        = 0;
        busy_ready = 1'b0;
        while (!m_axis_result_tvalid && lat < 20) begin
            busy_ready      = busy_ready | s_axis_tready;
            s_axis_a_tdata  = $urandom;
            s_axis_b_tdata  = BW'($urandom);
            s_axis_a_tvalid = 1'($urandom_range(0, 1));
            s_axis_b_tvalid = 1'($urandom_range(0, 1));
            @(posedge aclk);
            @(negedge aclk);
            lat++;
        end
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        if (!m_axis_result_tvalid) lat = -1;
        d = m_axis_result_tdata;
        u = m_axis_result_tuser;
        @(posedge aclk);
        @(negedge aclk);
        after_valid = m_axis_result_tvalid;
        after_ready = s_axis_tready;
        after_data  = m_axis_result_tdata;
    endtask

    task automatic test_reset;
        aresetn         = 1'b0;
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        s_axis_a_tdata  = '0;
        s_axis_b_tdata  = '0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({s_axis_tready, m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser}
            !== {1'b1, 1'b0, {AW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b data=%h user=%b exp rdy=1 vld=0 data=0 user=0",
                     s_axis_tready, m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser);
        end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic;
        int lat; logic [AW-1:0] d, ad; logic u, av, ar, br;
        run_op(32'd1000, 8'd7, lat, d, u, av, ar, ad, br);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
        checks++;
        if (d !== 32'd7000) begin errors++; $display("FAIL basic_data got %0d exp 7000", d); end
        checks++;
        if (u !== 1'b0) begin errors++; $display("FAIL basic_user got %b exp 0", u); end
        checks++;
        if (av !== 1'b0) begin errors++; $display("FAIL basic_single_strobe got %b exp 0", av); end
        checks++;
        if (ar !== 1'b1) begin errors++; $display("FAIL basic_ready_return got %b exp 1", ar); end
        checks++;
        if (br !== 1'b0) begin errors++; $display("FAIL basic_busy_ready got %b exp 0", br); end
        checks++;
        if (ad !== 32'd7000) begin errors++; $display("FAIL basic_hold got %0d exp 7000", ad); end
    endtask

    task automatic test_saturation;
        logic [AW-1:0] ta [3];
        logic          tu [3];
        int lat; logic [AW-1:0] d, ad; logic u, av, ar, br;
        ta[0] = 32'hFFFF_FFFF; tu[0] = 1'b1;
        ta[1] = 32'h0101_0101; tu[1] = 1'b0;
        ta[2] = 32'h0101_0102; tu[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], 8'hFF, lat, d, u, av, ar, ad, br);
            checks++;
            if (d !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL sat_data[%0d] got %h exp ffffffff", i, d);
            end
            checks++;
            if (u !== tu[i]) begin
                errors++; $display("FAIL sat_user[%0d] got %b exp %b", i, u, tu[i]);
            end
        end
    endtask

    task automatic test_single_channel;
        int lat; logic [AW-1:0] d, ad, a; logic [BW-1:0] b; logic u, av, ar, br;
        logic [AW:0] e;
        logic bad;
        a = $urandom | 32'h1;
        b = BW'($urandom) | 8'h1;
        @(negedge aclk);
        s_axis_a_tdata  = a;
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(posedge aclk);
            @(negedge aclk);
            if (s_axis_tready !== 1'b1 || m_axis_result_tvalid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL single_channel_idle got rdy=%b vld=%b exp rdy=1 vld=0",
                               s_axis_tready, m_axis_result_tvalid);
        end
        e = model(a, b);
        run_op(a, b, lat, d, u, av, ar, ad, br);
        checks++;
        if ({u, d} !== e) begin
            errors++; $display("FAIL single_channel_result got %b/%h exp %b/%h", u, d, e[AW], e[AW-1:0]);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [AW-1:0] d, ad; logic u, av, ar, br;
        logic seen;
        @(negedge aclk);
        s_axis_a_tdata  = 32'd12345;
        s_axis_b_tdata  = 8'd99;
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser}
            !== {1'b1, 1'b0, {AW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_outputs got rdy=%b vld=%b data=%h user=%b exp rdy=1 vld=0 data=0 user=0",
                     s_axis_tready, m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge aclk);
            if (m_axis_result_tvalid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_strobe got %b exp 0", seen); end
        run_op(32'd3, 8'd5, lat, d, u, av, ar, ad, br);
        checks++;
        if (d !== 32'd15 || u !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after got %0d/%b exp 15/0", d, u);
        end
    endtask

    task automatic test_back_to_back;
        logic [AW:0] q[$];
        int          acc_cyc[$];
        logic [AW:0] e;
        int cyc, n_acc, n_res, last_acc, ac;
        cyc = 0; n_acc = 0; n_res = 0; last_acc = -1;
        @(negedge aclk);
        s_axis_a_tdata  = $urandom;
        s_axis_b_tdata  = BW'($urandom);
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b1;
        while (n_res < 5 && cyc < 200) begin
            if (s_axis_tready && s_axis_a_tvalid && s_axis_b_tvalid) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 10) begin
                        errors++; $display("FAIL b2b_spacing got %0d exp 10", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                q.push_back(model(s_axis_a_tdata, s_axis_b_tdata));
                acc_cyc.push_back(cyc);
                n_acc++;
            end else begin
                s_axis_a_tdata  = $urandom;
                s_axis_b_tdata  = (n_acc == 2) ? 8'd0 : BW'($urandom);
                s_axis_a_tvalid = (n_acc < 5);
                s_axis_b_tvalid = (n_acc < 5);
            end
            if (m_axis_result_tvalid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected got strobe exp none");
                end else begin
                    e  = q.pop_front();
                    ac = acc_cyc.pop_front();
                    if ({m_axis_result_tuser, m_axis_result_tdata} !== e) begin
                        errors++;
                        $display("FAIL b2b_result[%0d] got %b/%h exp %b/%h", n_res,
                                 m_axis_result_tuser, m_axis_result_tdata, e[AW], e[AW-1:0]);
                    end
                    checks++;
                    if (cyc - ac !== 9) begin
                        errors++; $display("FAIL b2b_latency[%0d] got %0d exp 9", n_res, cyc - ac);
                    end
                end
                n_res++;
            end
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
        end
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        checks++;
        if (n_res !== 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", n_res); end
    endtask

    task automatic test_random;
        int lat; logic [AW-1:0] d, ad, a; logic [BW-1:0] b; logic u, av, ar, br;
        logic [AW:0] e;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       a = $urandom;
                1:       a = $urandom >> $urandom_range(4, 31);
                default: a = 32'h0101_0100 + AW'($urandom_range(0, 3));
            endcase
            b = BW'($urandom);
            e = model(a, b);
            run_op(a, b, lat, d, u, av, ar, ad, br);
            checks++;
            if ({u, d} !== e || lat !== 8) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h got %b/%h lat %0d exp %b/%h lat 8",
                         i, a, b, u, d, lat, e[AW], e[AW-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_single_channel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_fix_seq_32_8.md
MULT_FIX_SEQ_32_8 -- requirements
Module: mult_fix_seq_32_8

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32, the multiplicand and result width.
REQ-002 SHALL have parameter B_WIDTH, default 8, the multiplier width and the iteration count.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_a_tvalid, input, 1 bit: multiplicand valid.
REQ-006 SHALL have port s_axis_a_tdata, input, A_WIDTH bits: unsigned multiplicand.
REQ-007 SHALL have port s_axis_b_tvalid, input, 1 bit: multiplier valid.
REQ-008 SHALL have port s_axis_b_tdata, input, B_WIDTH bits: unsigned multiplier.
REQ-009 SHALL have port s_axis_tready, output, 1 bit: block can accept operands; shared by both input channels.
REQ-010 SHALL have port m_axis_result_tvalid, output, 1 bit: one-cycle result strobe.
REQ-011 SHALL have port m_axis_result_tdata, output, A_WIDTH bits: saturated product.
REQ-012 SHALL have port m_axis_result_tuser, output, 1 bit: saturation flag for the current result.

Function
REQ-013 SHALL implement the states IDLE, CALC and DONE.
REQ-014 SHALL drive s_axis_tready = 1 in IDLE only and 0 in CALC and DONE.
REQ-015 SHALL accept operands only at an edge where s_axis_tready, s_axis_a_tvalid and s_axis_b_tvalid are all 1; on accept, capture both operands, clear the 40-bit (A_WIDTH+B_WIDTH) accumulator and the iteration counter, and move to CALC.
REQ-016 SHALL ignore the inputs if only one tvalid is high in IDLE: no capture, no partial latching, remain in IDLE.
REQ-017 SHALL perform one shift-add iteration per edge in CALC, LSB of the multiplier first: when the current multiplier bit is 1, add the multiplicand shifted left by the iteration index into the accumulator.
REQ-018 SHALL complete exactly B_WIDTH iterations independent of operand values, including a zero multiplier; the edge that performs iteration B_WIDTH-1 moves to DONE.
REQ-019 SHALL register the result on entry to DONE: if accumulator > 2^A_WIDTH-1, tdata = all ones and tuser = 1; otherwise tdata = accumulator[A_WIDTH-1:0] and tuser = 0.
REQ-020 SHALL assert m_axis_result_tvalid for exactly the one cycle spent in DONE; there is no output backpressure, so the result is lost if it is not sampled in that cycle.
REQ-021 SHALL move from DONE to IDLE unconditionally at the next edge.
REQ-022 SHALL have a latency where, with accept at edge E0, tvalid is high during the cycle after edge E(B_WIDTH) (E8 at default widths), and s_axis_tready returns high after edge E(B_WIDTH+1).
REQ-023 SHALL support a minimum accept-to-accept spacing of B_WIDTH+2 cycles (10 at default widths).
REQ-024 SHALL hold m_axis_result_tdata and m_axis_result_tuser at the last result until the next DONE entry.
REQ-025 SHALL ignore input tvalid and tdata changes during CALC and DONE; the captured operands are unaffected.
REQ-026 SHALL treat an exact product of 2^A_WIDTH-1 as not saturated (tuser = 0).

Reset
REQ-027 SHALL, while aresetn = 0, force state = IDLE, s_axis_tready = 1, m_axis_result_tvalid = 0, m_axis_result_tdata = 0, m_axis_result_tuser = 0, and clear the accumulator, counter and operand registers, asynchronously.
REQ-028 SHALL abandon any operation in progress when reset is asserted mid-CALC or in DONE, with no result strobe afterwards; after release, the first accept SHALL produce a correct result.

Verification
REQ-029 SHALL cover a basic multiply: a = 1000, b = 7, both valid for one cycle -> tdata = 7000, tuser = 0, tvalid a single cycle, 9 cycles after the accept edge.
REQ-030 SHALL cover saturation: a = 0xFFFFFFFF, b = 0xFF -> tdata = 0xFFFFFFFF, tuser = 1.
REQ-031 SHALL cover the saturation boundary: a = 0x01010101, b = 0xFF -> tdata = 0xFFFFFFFF, tuser = 0; and a = 0x01010102, b = 0xFF -> tdata = 0xFFFFFFFF, tuser = 1.
REQ-032 SHALL cover single-channel valid: a_tvalid = 1, b_tvalid = 0 for 5 cycles -> no accept, tready stays 1, no tvalid; then b_tvalid = 1 -> accept, correct product.
REQ-033 SHALL cover reset mid-operation: aresetn pulled low 4 cycles after accept -> outputs go to 0 immediately, tready = 1, and no tvalid follows; a later a = 3, b = 5 -> tdata = 15.
REQ-034 SHALL cover back-to-back operation: both tvalid held high with changing operands -> accepts 10 cycles apart, each result matches the operands captured at its own accept edge, and b = 0 gives tdata = 0 with the full 9-cycle latency.
